// File: rtl/ct_mat_lsu_row_seq.sv
// ct_mat_lsu_row_seq
//   Matrix load/store row sequencer. Captures one matrix memory instruction
//   from the issue pipe, emits one memory request per row (base + row*stride,
//   built incrementally), then signals completion on the completion bus for
//   exactly one cycle.
//
//   Optional feature: define MAT_LSU_PERF_CNT_EN to add the 32-bit saturating
//   request stall counter and its output port mat_lsu_stall_cnt.
module ct_mat_lsu_row_seq #(
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 8,
    parameter int IID_WIDTH  = 7
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  cp0_mat_icg_en,
    input  logic                  cp0_yy_clk_en,
    input  logic                  pad_yy_icg_scan_en,
    input  logic                  rtu_yy_xx_flush,
    input  logic                  idu_mat_rf_lsu_sel,
    input  logic                  idu_mat_rf_lsu_gateclk_sel,
    input  logic [IID_WIDTH-1:0]  idu_mat_rf_pipe8_iid,
    input  logic [15:0]           idu_mat_rf_pipe8_lsu_meta,
    input  logic [ADDR_WIDTH-1:0] idu_mat_rf_pipe8_lsu_src0,
    input  logic                  idu_mat_rf_pipe8_lsu_src1_vld,
    input  logic [ADDR_WIDTH-1:0] idu_mat_rf_pipe8_lsu_src1,
    input  logic [15:0]           x_sizeK,
    input  logic [7:0]            x_sizeM,
    output logic                  mat_lsu_idu_rdy,
    output logic                  mat_lsu_req_vld,
    input  logic                  lsu_mat_req_rdy,
    output logic [ADDR_WIDTH-1:0] mat_lsu_req_addr,
    output logic [1:0]            mat_lsu_req_op,
    output logic [2:0]            mat_lsu_req_mreg,
    output logic [1:0]            mat_lsu_req_width,
    output logic [CNT_WIDTH-1:0]  mat_lsu_req_row,
    output logic                  mat_lsu_req_last,
    output logic                  mat_lsu_cbus_ex1_pipe8_sel,
    output logic [IID_WIDTH-1:0]  mat_lsu_cbus_ex1_pipe8_iid
`ifdef MAT_LSU_PERF_CNT_EN
    ,
    output logic [31:0]           mat_lsu_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [IID_WIDTH-1:0]    iid_reg;
    logic [1:0]              op_reg;
    logic [2:0]              mreg_reg;
    logic [1:0]              width_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [ADDR_WIDTH-1:0]   stride_reg;
    logic [CNT_WIDTH-1:0]    cnt_reg;
    logic [CNT_WIDTH-1:0]    row_reg;

    // Decoded issue-side fields.
    logic [1:0]              meta_op;
    logic [2:0]              meta_dstm_idx;
    logic [2:0]              meta_src2m_idx;
    logic [1:0]              meta_width;
    logic [CNT_WIDTH-1:0]    row_cnt;
    logic [ADDR_WIDTH-1:0]   stride_sel;
    logic                    no_rows;

    logic                    capture;
    logic                    accept;
    logic                    last_row;
    logic                    ctrl_clk_en;
    logic                    data_clk_en;
    logic                    unused_meta;

    assign meta_op        = idu_mat_rf_pipe8_lsu_meta[15:14];
    assign meta_dstm_idx  = idu_mat_rf_pipe8_lsu_meta[12:10];
    assign meta_src2m_idx = idu_mat_rf_pipe8_lsu_meta[8:6];
    assign meta_width     = idu_mat_rf_pipe8_lsu_meta[1:0];
    assign row_cnt        = CNT_WIDTH'(x_sizeM);
    assign stride_sel     = idu_mat_rf_pipe8_lsu_src1_vld ? idu_mat_rf_pipe8_lsu_src1
                                                          : ADDR_WIDTH'(x_sizeK);

    // Reserved ops and zero-row instructions complete without touching memory.
    assign no_rows = (meta_op == 2'b00) || (meta_op == 2'b11) || (row_cnt == '0);

    // Valid/vld qualifier bits and nf fields are not needed for row sequencing.
    assign unused_meta = ^{idu_mat_rf_pipe8_lsu_meta[13], idu_mat_rf_pipe8_lsu_meta[9],
                           idu_mat_rf_pipe8_lsu_meta[5:2], x_sizeM};

    assign capture  = (state_reg == IDLE) && idu_mat_rf_lsu_sel && !rtu_yy_xx_flush;
    assign accept   = (state_reg == ISSUE) && lsu_mat_req_rdy;
    assign last_row = (row_reg == (cnt_reg - CNT_WIDTH'(1)));

    // Clock-gate enables, modelled as register enables: global enable qualifies
    // the local/module enables, and scan forces the clock on.
    assign ctrl_clk_en = (cp0_yy_clk_en && (idu_mat_rf_lsu_gateclk_sel
                                            || (state_reg != IDLE)
                                            || cp0_mat_icg_en))
                         || pad_yy_icg_scan_en;
    assign data_clk_en = (cp0_yy_clk_en && (idu_mat_rf_lsu_gateclk_sel
                                            || (state_reg == ISSUE)
                                            || cp0_mat_icg_en))
                         || pad_yy_icg_scan_en;

    // Control FSM: IDLE -> ISSUE (per-row requests) -> DONE (completion) -> IDLE.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_reg <= IDLE;
        end else if (ctrl_clk_en) begin
            if (rtu_yy_xx_flush) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (capture) begin
                            state_reg <= no_rows ? DONE : ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (accept && last_row) begin
                            state_reg <= DONE;
                        end
                    end
                    DONE:    state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Instruction capture, then per-row address/row advance on each accepted request.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            iid_reg    <= '0;
            op_reg     <= '0;
            mreg_reg   <= '0;
            width_reg  <= '0;
            addr_reg   <= '0;
            stride_reg <= '0;
            cnt_reg    <= '0;
            row_reg    <= '0;
        end else if (data_clk_en) begin
            if (capture) begin
                iid_reg    <= idu_mat_rf_pipe8_iid;
                op_reg     <= meta_op;
                mreg_reg   <= (meta_op == 2'b10) ? meta_src2m_idx : meta_dstm_idx;
                width_reg  <= meta_width;
                addr_reg   <= idu_mat_rf_pipe8_lsu_src0;
                stride_reg <= stride_sel;
                cnt_reg    <= row_cnt;
                row_reg    <= '0;
            end else if (accept && !rtu_yy_xx_flush) begin
                row_reg    <= row_reg + CNT_WIDTH'(1);
                addr_reg   <= addr_reg + stride_reg;
            end
        end
    end

`ifdef MAT_LSU_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Saturating count of cycles where a row request waits on the LSU.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ISSUE) && !lsu_mat_req_rdy && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign mat_lsu_stall_cnt = stall_cnt_reg;
`endif

    assign mat_lsu_idu_rdy            = (state_reg == IDLE);
    assign mat_lsu_req_vld            = (state_reg == ISSUE);
    assign mat_lsu_req_addr           = addr_reg;
    assign mat_lsu_req_op             = op_reg;
    assign mat_lsu_req_mreg           = mreg_reg;
    assign mat_lsu_req_width          = width_reg;
    assign mat_lsu_req_row            = row_reg;
    assign mat_lsu_req_last           = (state_reg == ISSUE) && last_row;
    assign mat_lsu_cbus_ex1_pipe8_sel = (state_reg == DONE);
    assign mat_lsu_cbus_ex1_pipe8_iid = iid_reg;

endmodule

// File: tb/tb_ct_mat_lsu_row_seq.sv
// Testbench for ct_mat_lsu_row_seq: directed scenarios plus randomized
// transactions checked against an arithmetic reference (addr = src0 + row*stride).
module tb_ct_mat_lsu_row_seq;

    localparam int AW = 64;
    localparam int CW = 8;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          icg_en = 1'b0;
    logic          clk_en = 1'b1;
    logic          scan_en = 1'b0;
    logic          flush = 1'b0;
    logic          sel = 1'b0;
    logic          gsel = 1'b0;
    logic [IW-1:0] iid_in = '0;
    logic [15:0]   meta = '0;
    logic [AW-1:0] src0 = '0;
    logic          s1v = 1'b0;
    logic [AW-1:0] src1 = '0;
    logic [15:0]   size_k = '0;
    logic [7:0]    size_m = '0;
    logic          lsu_rdy = 1'b0;

    logic          idu_rdy;
    logic          req_vld;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_op;
    logic [2:0]    req_mreg;
    logic [1:0]    req_width;
    logic [CW-1:0] req_row;
    logic          req_last;
    logic          cb_sel;
    logic [IW-1:0] cb_iid;
`ifdef MAT_LSU_PERF_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int model_stall = 0;

    ct_mat_lsu_row_seq #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .IID_WIDTH(IW)) dut (
        .forever_cpuclk                (clk),
        .cpurst_b                      (rst_n),
        .cp0_mat_icg_en                (icg_en),
        .cp0_yy_clk_en                 (clk_en),
        .pad_yy_icg_scan_en            (scan_en),
        .rtu_yy_xx_flush               (flush),
        .idu_mat_rf_lsu_sel            (sel),
        .idu_mat_rf_lsu_gateclk_sel    (gsel),
        .idu_mat_rf_pipe8_iid          (iid_in),
        .idu_mat_rf_pipe8_lsu_meta     (meta),
        .idu_mat_rf_pipe8_lsu_src0     (src0),
        .idu_mat_rf_pipe8_lsu_src1_vld (s1v),
        .idu_mat_rf_pipe8_lsu_src1     (src1),
        .x_sizeK                       (size_k),
        .x_sizeM                       (size_m),
        .mat_lsu_idu_rdy               (idu_rdy),
        .mat_lsu_req_vld               (req_vld),
        .lsu_mat_req_rdy               (lsu_rdy),
        .mat_lsu_req_addr              (req_addr),
        .mat_lsu_req_op                (req_op),
        .mat_lsu_req_mreg              (req_mreg),
        .mat_lsu_req_width             (req_width),
        .mat_lsu_req_row               (req_row),
        .mat_lsu_req_last              (req_last),
        .mat_lsu_cbus_ex1_pipe8_sel    (cb_sel),
        .mat_lsu_cbus_ex1_pipe8_iid    (cb_iid)
`ifdef MAT_LSU_PERF_CNT_EN
        ,
        .mat_lsu_stall_cnt             (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one cycle; all sampling and driving happens 2 time units after the edge.
    task automatic step();
        if (rst_n && req_vld && !lsu_rdy) model_stall++;
        @(posedge clk);
        #2;
    endtask

    // Present one instruction for one cycle, then scramble the issue inputs.
    task automatic issue(input logic [IW-1:0] iid, input logic [1:0] op,
                         input logic [2:0] dst, input logic [2:0] s2,
                         input logic [1:0] wd, input logic [AW-1:0] base,
                         input logic sv, input logic [AW-1:0] stride,
                         input logic [15:0] k, input logic [7:0] m);
        sel = 1'b1; gsel = 1'b1; iid_in = iid;
        meta = {op, 1'b1, dst, 1'b1, s2, 1'b0, 3'b000, wd};
        src0 = base; s1v = sv; src1 = stride; size_k = k; size_m = m;
        step();
        sel = 1'b0; gsel = 1'b0;
        iid_in = IW'($urandom); meta = 16'($urandom);
        src0 = {$urandom, $urandom}; src1 = {$urandom, $urandom};
        s1v = 1'($urandom); size_k = 16'($urandom); size_m = 8'($urandom);
    endtask

    task automatic test_reset();
        step(); step();
        n_checks++;
        if (idu_rdy !== 1'b1 || req_vld !== 1'b0 || cb_sel !== 1'b0 || req_last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy=%0b vld=%0b sel=%0b last=%0b want 1/0/0/0",
                     idu_rdy, req_vld, cb_sel, req_last);
        end
        n_checks++;
        if (req_addr !== '0 || req_row !== '0 || req_op !== '0 || req_mreg !== '0 ||
            req_width !== '0 || cb_iid !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h row=%0d op=%0d mreg=%0d wd=%0d iid=%0d want all 0",
                     req_addr, req_row, req_op, req_mreg, req_width, cb_iid);
        end
`ifdef MAT_LSU_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall: got %0d want 0", stall_cnt);
        end
`endif
        rst_n = 1'b1;
        step();
        n_checks++;
        if (idu_rdy !== 1'b1 || req_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%0b vld=%0b want 1/0", idu_rdy, req_vld);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_basic();
        logic [AW-1:0] exp_a [3];
        exp_a = '{64'h1000, 64'h1040, 64'h1080};
        lsu_rdy = 1'b1;
        issue(7'h15, 2'b01, 3'd3, 3'd6, 2'b10, 64'h1000, 1'b0, 64'hdead, 16'h40, 8'd3);
        for (int r = 0; r < 3; r++) begin
            n_checks++;
            if (req_vld !== 1'b1 || req_addr !== exp_a[r] || req_row !== 8'(r) ||
                req_last !== (r == 2) || req_op !== 2'b01 || req_mreg !== 3'd3 ||
                req_width !== 2'b10 || idu_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL load_row%0d: vld=%0b addr=%h row=%0d last=%0b op=%0d mreg=%0d wd=%0d rdy=%0b want addr=%h",
                         r, req_vld, req_addr, req_row, req_last, req_op, req_mreg,
                         req_width, idu_rdy, exp_a[r]);
            end
            step();
        end
        n_checks++;
        if (cb_sel !== 1'b1 || cb_iid !== 7'h15 || req_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: sel=%0b iid=%h vld=%0b want 1/15/0", cb_sel, cb_iid, req_vld);
        end
        step();
        n_checks++;
        if (cb_sel !== 1'b0 || idu_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_idle: sel=%0b rdy=%0b want 0/1", cb_sel, idu_rdy);
        end
        $display("test_load_basic done");
    endtask

    task automatic test_store_stall();
        logic [AW-1:0] base;
        base = 64'h0000_0000_0004_2000;
        lsu_rdy = 1'b0;
        issue(7'h2A, 2'b10, 3'd1, 3'd5, 2'b01, base, 1'b1, 64'h200, 16'h10, 8'd2);
        for (int c = 0; c < 5; c++) begin
            if (c == 4) lsu_rdy = 1'b1;
            n_checks++;
            if (req_vld !== 1'b1 || req_addr !== base || req_row !== 8'd0 || req_last !== 1'b0 ||
                req_mreg !== 3'd5 || req_op !== 2'b10 || req_width !== 2'b01) begin
                n_fail++;
                $display("FAIL store_hold%0d: vld=%0b addr=%h row=%0d last=%0b mreg=%0d op=%0d want 1/%h/0/0/5/2",
                         c, req_vld, req_addr, req_row, req_last, req_mreg, req_op, base);
            end
            step();
        end
        n_checks++;
        if (req_vld !== 1'b1 || req_addr !== base + 64'h200 || req_row !== 8'd1 || req_last !== 1'b1) begin
            n_fail++;
            $display("FAIL store_row1: vld=%0b addr=%h row=%0d last=%0b want 1/%h/1/1",
                     req_vld, req_addr, req_row, req_last, base + 64'h200);
        end
        step();
        n_checks++;
        if (cb_sel !== 1'b1 || cb_iid !== 7'h2A) begin
            n_fail++;
            $display("FAIL store_done: sel=%0b iid=%h want 1/2a", cb_sel, cb_iid);
        end
`ifdef MAT_LSU_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL store_stall_cnt: got %0d want 4", stall_cnt);
        end
`endif
        step();
        $display("test_store_stall done");
    endtask

    task automatic test_empty();
        logic [1:0] ops [2];
        logic [7:0] ms [2];
        ops = '{2'b01, 2'b11};
        ms  = '{8'd0, 8'd5};
        lsu_rdy = 1'b1;
        for (int t = 0; t < 2; t++) begin
            issue(7'(7'h30 + t), ops[t], 3'd2, 3'd4, 2'b00, 64'h8000, 1'b0, 64'h0, 16'h20, ms[t]);
            n_checks++;
            if (req_vld !== 1'b0 || cb_sel !== 1'b1 || cb_iid !== 7'(7'h30 + t) || idu_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL empty%0d_done: vld=%0b sel=%0b iid=%h rdy=%0b want 0/1/%h/0",
                         t, req_vld, cb_sel, cb_iid, idu_rdy, 7'(7'h30 + t));
            end
            step();
            n_checks++;
            if (req_vld !== 1'b0 || cb_sel !== 1'b0 || idu_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL empty%0d_idle: vld=%0b sel=%0b rdy=%0b want 0/0/1", t, req_vld, cb_sel, idu_rdy);
            end
        end
        $display("test_empty done");
    endtask

    task automatic test_flush();
        int sel_seen;
        lsu_rdy = 1'b1;
        issue(7'h44, 2'b01, 3'd7, 3'd0, 2'b11, 64'h3000, 1'b1, 64'h100, 16'h0, 8'd4);
        step();
        n_checks++;
        if (req_vld !== 1'b1 || req_row !== 8'd1 || req_addr !== 64'h3100) begin
            n_fail++;
            $display("FAIL flush_row1: vld=%0b row=%0d addr=%h want 1/1/3100", req_vld, req_row, req_addr);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if (req_vld !== 1'b0 || cb_sel !== 1'b0 || idu_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_after: vld=%0b sel=%0b rdy=%0b want 0/0/1", req_vld, cb_sel, idu_rdy);
        end
        sel_seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (cb_sel === 1'b1 || req_vld === 1'b1) sel_seen++;
        end
        n_checks++;
        if (sel_seen != 0) begin
            n_fail++;
            $display("FAIL flush_quiet: activity cycles=%0d want 0", sel_seen);
        end
        $display("test_flush done");
    endtask

    task automatic test_wrap();
        lsu_rdy = 1'b1;
        issue(7'h51, 2'b01, 3'd1, 3'd2, 2'b00, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 64'h40, 16'h0, 8'd2);
        n_checks++;
        if (req_vld !== 1'b1 || req_addr !== 64'hFFFF_FFFF_FFFF_FFC0 || req_last !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_row0: vld=%0b addr=%h last=%0b want 1/ffffffffffffffc0/0", req_vld, req_addr, req_last);
        end
        step();
        n_checks++;
        if (req_vld !== 1'b1 || req_addr !== 64'h0 || req_last !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_row1: vld=%0b addr=%h last=%0b want 1/0/1", req_vld, req_addr, req_last);
        end
        step();
        step();
        $display("test_wrap done");
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            logic [1:0]    op;
            logic [2:0]    dst, s2;
            logic [1:0]    wd;
            logic [AW-1:0] base, s1, stride, exp_addr;
            logic          sv;
            logic [15:0]   k;
            logic [7:0]    m;
            logic [IW-1:0] iid;
            logic [2:0]    exp_mreg;
            int            n, idx;
            bit            done;
            op = 2'($urandom_range(0, 3)); dst = 3'($urandom); s2 = 3'($urandom);
            wd = 2'($urandom); base = {$urandom, $urandom}; s1 = {$urandom, $urandom};
            sv = 1'($urandom); k = 16'($urandom); m = 8'($urandom_range(0, 5));
            iid = IW'($urandom);
            stride   = sv ? s1 : {48'd0, k};
            n        = (op == 2'b01 || op == 2'b10) ? int'(m) : 0;
            exp_mreg = (op == 2'b10) ? s2 : dst;
            lsu_rdy = 1'($urandom);
            issue(iid, op, dst, s2, wd, base, sv, s1, k, m);
            idx = 0;
            done = 0;
            for (int c = 0; c < 80 && !done; c++) begin
                if (req_vld === 1'b1) begin
                    exp_addr = base + stride * 64'(idx);
                    n_checks++;
                    if (idx >= n || req_addr !== exp_addr || req_row !== 8'(idx) ||
                        req_last !== (idx == n - 1) || req_op !== op ||
                        req_mreg !== exp_mreg || req_width !== wd) begin
                        n_fail++;
                        $display("FAIL rand%0d_req%0d: addr=%h row=%0d last=%0b op=%0d mreg=%0d wd=%0d want addr=%h rows=%0d op=%0d mreg=%0d wd=%0d",
                                 t, idx, req_addr, req_row, req_last, req_op, req_mreg, req_width,
                                 exp_addr, n, op, exp_mreg, wd);
                    end
                end
                if (cb_sel === 1'b1) begin
                    n_checks++;
                    if (idx != n || cb_iid !== iid || req_vld !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand%0d_done: rows=%0d iid=%h vld=%0b want rows=%0d iid=%h vld=0",
                                 t, idx, cb_iid, req_vld, n, iid);
                    end
                    done = 1;
                end
                lsu_rdy = 1'($urandom);
                if (req_vld === 1'b1 && lsu_rdy) idx++;
                step();
            end
            n_checks++;
            if (!done || idu_rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_finish: completed=%0b rdy=%0b want 1/1", t, done, idu_rdy);
            end
            $display("rand txn %0d op=%0d rows=%0d iid=%h", t, op, n, iid);
        end
`ifdef MAT_LSU_PERF_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'(model_stall)) begin
            n_fail++;
            $display("FAIL rand_stall_cnt: got %0d want %0d", stall_cnt, model_stall);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int sel_seen;
        lsu_rdy = 1'b0;
        issue(7'h66, 2'b10, 3'd0, 3'd3, 2'b01, 64'h9000, 1'b1, 64'h80, 16'h0, 8'd4);
        step();
        n_checks++;
        if (req_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: vld=%0b want 1", req_vld);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (req_vld !== 1'b0 || idu_rdy !== 1'b1 || cb_sel !== 1'b0 || req_addr !== '0 ||
            req_row !== '0 || req_op !== '0 || req_mreg !== '0 || cb_iid !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: vld=%0b rdy=%0b sel=%0b addr=%h row=%0d op=%0d mreg=%0d iid=%h want reset values",
                     req_vld, idu_rdy, cb_sel, req_addr, req_row, req_op, req_mreg, cb_iid);
        end
        model_stall = 0;
        step();
        rst_n = 1'b1;
        sel_seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (cb_sel === 1'b1 || req_vld === 1'b1) sel_seen++;
        end
        n_checks++;
        if (sel_seen != 0 || idu_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_quiet: activity=%0d rdy=%0b want 0/1", sel_seen, idu_rdy);
        end
        lsu_rdy = 1'b1;
        issue(7'h12, 2'b01, 3'd4, 3'd1, 2'b10, 64'hA000, 1'b0, 64'h0, 16'h8, 8'd2);
        n_checks++;
        if (req_vld !== 1'b1 || req_addr !== 64'hA000 || req_row !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_new0: vld=%0b addr=%h row=%0d want 1/a000/0", req_vld, req_addr, req_row);
        end
        step();
        n_checks++;
        if (req_vld !== 1'b1 || req_addr !== 64'hA008 || req_last !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_new1: vld=%0b addr=%h last=%0b want 1/a008/1", req_vld, req_addr, req_last);
        end
        step();
        n_checks++;
        if (cb_sel !== 1'b1 || cb_iid !== 7'h12) begin
            n_fail++;
            $display("FAIL rstmid_done: sel=%0b iid=%h want 1/12", cb_sel, cb_iid);
        end
        step();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_stall();
        test_empty();
        test_flush();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
